// File: rtl/wb_stage_q_if.sv
// Bus bundle for the write-back stage.
//   m_*      : M/W pipeline slot inputs, w_stall back-pressure to M
//   x_*      : long-latency result offer, x_ready acceptance
//   rf_*     : single register-file write port
// master = pipeline/testbench side, slave = wb_stage_q side.
interface wb_stage_q_if #(
  parameter int unsigned DATA_W = 32
);
  logic              m_valid;
  logic [31:0]       m_ir;
  logic [31:0]       m_pc4;
  logic [DATA_W-1:0] m_ao;
  logic [DATA_W-1:0] m_dr;
  logic              w_stall;
  logic              x_valid;
  logic [4:0]        x_addr;
  logic [DATA_W-1:0] x_data;
  logic              x_ready;
  logic              rf_we;
  logic [4:0]        rf_a3;
  logic [DATA_W-1:0] rf_wd;

  modport master (
    output m_valid, m_ir, m_pc4, m_ao, m_dr, x_valid, x_addr, x_data,
    input  w_stall, x_ready, rf_we, rf_a3, rf_wd
  );

  modport slave (
    input  m_valid, m_ir, m_pc4, m_ao, m_dr, x_valid, x_addr, x_data,
    output w_stall, x_ready, rf_we, rf_a3, rf_wd
  );
endinterface

// File: rtl/wb_stage_q.sv
// Registered MIPS write-back stage with a long-latency result FIFO that
// shares the single register-file write port.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : wb_stage_q_if.slave (M slot in, w_stall out, x result in,
//           x_ready out, rf_we/rf_a3/rf_wd write port out)
// rf_* are decoded combinationally from registered state (slot + FIFO),
// so a write appears in the cycle after capture and drops at once on reset.
module wb_stage_q #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned XQ_DEPTH = 4,
  parameter int unsigned LINK_OFS = 4
) (
  input  logic         clk,
  input  logic         reset,
  wb_stage_q_if.slave  bus
);

  localparam int unsigned AW = $clog2(XQ_DEPTH);
  localparam int unsigned CW = AW + 1;

  // W slot
  logic              s_valid;
  logic [31:0]       s_ir;
  logic [31:0]       s_pc4;
  logic [DATA_W-1:0] s_ao;
  logic [DATA_W-1:0] s_dr;

  // FIFO state
  logic [4:0]        q_addr [XQ_DEPTH];
  logic [DATA_W-1:0] q_data [XQ_DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic [CW-1:0]     count;

  // Decode / arbitration
  logic              reg_write;
  logic              is_link;
  logic              is_load;
  logic [4:0]        dest;
  logic [31:0]       ld_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] slot_data;
  logic              slot_wr;
  logic              full;
  logic              empty;
  logic              head_sel;
  logic              push;
  logic              pop;
  logic              stall;
  logic [31:0]       dr32;

  wire [5:0] op    = s_ir[31:26];
  wire [4:0] rt    = s_ir[20:16];
  wire [4:0] rd    = s_ir[15:11];
  wire [5:0] funct = s_ir[5:0];

  // rs and shamt are not needed for write-back
  logic unused_ir;
  assign unused_ir = ^{s_ir[25:21], s_ir[10:6]};

  // Slot capture; holds while back-pressured
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_valid <= 1'b0;
      s_ir    <= '0;
      s_pc4   <= '0;
      s_ao    <= '0;
      s_dr    <= '0;
    end else if (!stall) begin
      s_valid <= bus.m_valid;
      s_ir    <= bus.m_ir;
      s_pc4   <= bus.m_pc4;
      s_ao    <= bus.m_ao;
      s_dr    <= bus.m_dr;
    end
  end

  // Instruction decode: write enable, destination, data source
  always_comb begin
    reg_write = 1'b0;
    is_link   = 1'b0;
    is_load   = 1'b0;
    dest      = 5'd0;
    case (op)
      6'h00: begin
        reg_write = (funct != 6'h08);
        is_link   = (funct == 6'h09);
        dest      = rd;
      end
      6'h03: begin
        reg_write = 1'b1;
        is_link   = 1'b1;
        dest      = 5'd31;
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
        reg_write = 1'b1;
        dest      = rt;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        reg_write = 1'b1;
        is_load   = 1'b1;
        dest      = rt;
      end
      default: ;
    endcase
  end

  // Load extension: little-endian lane select from ao[1:0]
  assign dr32 = 32'(s_dr);

  always_comb begin
    ld_byte = dr32[7:0];
    case (s_ao[1:0])
      2'd0: ld_byte = dr32[7:0];
      2'd1: ld_byte = dr32[15:8];
      2'd2: ld_byte = dr32[23:16];
      2'd3: ld_byte = dr32[31:24];
      default: ;
    endcase
    ld_half = s_ao[1] ? dr32[31:16] : dr32[15:0];
    ld_word = dr32;
    case (op)
      6'h20: ld_word = {{24{ld_byte[7]}}, ld_byte};
      6'h24: ld_word = {24'd0, ld_byte};
      6'h21: ld_word = {{16{ld_half[15]}}, ld_half};
      6'h25: ld_word = {16'd0, ld_half};
      default: ld_word = dr32;
    endcase
  end

  always_comb begin
    slot_data = s_ao;
    if (is_link)
      slot_data = DATA_W'(s_pc4 + 32'(LINK_OFS));
    else if (is_load)
      slot_data = DATA_W'(ld_word);
  end

  // Write-port arbitration: full FIFO wins, else slot, else FIFO head
  assign slot_wr  = s_valid && reg_write && (dest != 5'd0);
  assign full     = (count == CW'(XQ_DEPTH));
  assign empty    = (count == CW'(0));
  assign head_sel = full || (!slot_wr && !empty);
  assign pop      = head_sel;
  assign stall    = full && slot_wr;
  assign push     = bus.x_valid && !full;

  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_a3 = 5'd0;
    bus.rf_wd = '0;
    if (head_sel) begin
      bus.rf_we = (q_addr[rp] != 5'd0);
      bus.rf_a3 = q_addr[rp];
      bus.rf_wd = q_data[rp];
    end else if (slot_wr) begin
      bus.rf_we = 1'b1;
      bus.rf_a3 = dest;
      bus.rf_wd = slot_data;
    end
  end

  assign bus.w_stall = stall;
  assign bus.x_ready = !full;

  // FIFO storage; contents are don't-care while count excludes them
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wp] <= bus.x_addr;
      q_data[wp] <= bus.x_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap at the power-of-2 depth
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage_q.sv
module tb_wb_stage_q;

  localparam logic [31:0] LB     = 32'h80050000;
  localparam logic [31:0] LBU    = 32'h90050000;
  localparam logic [31:0] LH     = 32'h84050000;
  localparam logic [31:0] LHU    = 32'h94050000;
  localparam logic [31:0] LW     = 32'h8C050000;
  localparam logic [31:0] JAL    = 32'h0C000000;
  localparam logic [31:0] JALR4  = 32'h00002009;
  localparam logic [31:0] ADDIU0 = 32'h24000000;
  localparam logic [31:0] ADDIU7 = 32'h24070000;
  localparam logic [31:0] JR     = 32'h03E00008;
  localparam logic [31:0] ADDU9  = 32'h00004821;
  localparam logic [31:0] ADDU2  = 32'h00001021;
  localparam logic [31:0] SW     = 32'hAC000000;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  wb_stage_q_if #(.DATA_W(32)) bus ();

  wb_stage_q #(.DATA_W(32), .XQ_DEPTH(4), .LINK_OFS(4)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic m_set(input logic v, input logic [31:0] ir, input logic [31:0] pc4,
                       input logic [31:0] ao, input logic [31:0] dr);
    bus.m_valid = v;
    bus.m_ir    = ir;
    bus.m_pc4   = pc4;
    bus.m_ao    = ao;
    bus.m_dr    = dr;
  endtask

  task automatic x_set(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.x_valid = v;
    bus.x_addr  = a;
    bus.x_data  = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [4:0] a3,
                        input logic [31:0] wd);
    chk({tag, ".we"}, 32'(bus.rf_we), 32'(we));
    chk({tag, ".a3"}, 32'(bus.rf_a3), 32'(a3));
    chk({tag, ".wd"}, bus.rf_wd, wd);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    m_set(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    x_set(1'b0, 5'd0, 32'd0);
    #1;
    chk_rf("reset", 1'b0, 5'd0, 32'd0);
    chk("reset.w_stall", 32'(bus.w_stall), 32'd0);
    chk("reset.x_ready", 32'(bus.x_ready), 32'd1);
    step();
    step();
    rst_n = 1'b1;

    // Load extension, link and suppressed writes
    m_set(1'b1, LB, 32'd0, 32'h1002, 32'h12F45678);
    step(); chk_rf("lb", 1'b1, 5'd5, 32'hFFFFFFF4);
    m_set(1'b1, LBU, 32'd0, 32'h1002, 32'h12F45678);
    step(); chk_rf("lbu", 1'b1, 5'd5, 32'h000000F4);
    m_set(1'b1, LH, 32'd0, 32'h1002, 32'h12F45678);
    step(); chk_rf("lh_hi", 1'b1, 5'd5, 32'h000012F4);
    m_set(1'b1, LH, 32'd0, 32'h1001, 32'h12F4A678);
    step(); chk_rf("lh_lo_odd", 1'b1, 5'd5, 32'hFFFFA678);
    m_set(1'b1, LHU, 32'd0, 32'h1000, 32'h12F4A678);
    step(); chk_rf("lhu", 1'b1, 5'd5, 32'h0000A678);
    m_set(1'b1, LW, 32'd0, 32'h1000, 32'h12F4A678);
    step(); chk_rf("lw", 1'b1, 5'd5, 32'h12F4A678);
    m_set(1'b1, JAL, 32'h3004, 32'd0, 32'd0);
    step(); chk_rf("jal", 1'b1, 5'd31, 32'h3008);
    m_set(1'b1, JALR4, 32'h4000, 32'd0, 32'd0);
    step(); chk_rf("jalr", 1'b1, 5'd4, 32'h4004);
    m_set(1'b1, ADDIU0, 32'd0, 32'h77, 32'd0);
    step(); chk_rf("addiu_r0", 1'b0, 5'd0, 32'd0);
    m_set(1'b1, ADDIU7, 32'd0, 32'h77, 32'd0);
    step(); chk_rf("addiu_r7", 1'b1, 5'd7, 32'h77);
    m_set(1'b1, JR, 32'd0, 32'h55, 32'd0);
    step(); chk_rf("jr", 1'b0, 5'd0, 32'd0);

    // Slot has priority; FIFO entry waits for a free port (sw)
    m_set(1'b1, ADDU9, 32'd0, 32'h111, 32'd0);
    x_set(1'b1, 5'd8, 32'hAA);
    step(); x_set(1'b0, 5'd0, 32'd0);
    chk_rf("slot_pri0", 1'b1, 5'd9, 32'h111);
    step(); chk_rf("slot_pri1", 1'b1, 5'd9, 32'h111);
    m_set(1'b1, SW, 32'd0, 32'h2000, 32'd0);
    step(); chk_rf("sw_drain", 1'b1, 5'd8, 32'hAA);
    m_set(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    step(); chk_rf("idle", 1'b0, 5'd0, 32'd0);

    // Fill to full while slot writes; stall one cycle per full head write
    m_set(1'b1, ADDU9, 32'd0, 32'h222, 32'd0);
    for (int k = 0; k < 4; k++) begin
      x_set(1'b1, 5'(10 + k), 32'(32'hD0 + k));
      step();
      if (k < 3) begin
        chk_rf("fill", 1'b1, 5'd9, 32'h222);
        chk("fill.x_ready", 32'(bus.x_ready), 32'd1);
        chk("fill.w_stall", 32'(bus.w_stall), 32'd0);
      end
    end
    chk("full.x_ready", 32'(bus.x_ready), 32'd0);
    chk("full.w_stall", 32'(bus.w_stall), 32'd1);
    chk_rf("full.head", 1'b1, 5'd10, 32'hD0);
    x_set(1'b0, 5'd0, 32'd0);
    m_set(1'b1, ADDU2, 32'd0, 32'h333, 32'd0);
    step();
    chk("held.w_stall", 32'(bus.w_stall), 32'd0);
    chk("held.x_ready", 32'(bus.x_ready), 32'd1);
    chk_rf("held.slot", 1'b1, 5'd9, 32'h222);
    step(); chk_rf("next.slot", 1'b1, 5'd2, 32'h333);
    m_set(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    step(); chk_rf("drain1", 1'b1, 5'd11, 32'hD1);
    step(); chk_rf("drain2", 1'b1, 5'd12, 32'hD2);
    step(); chk_rf("drain3", 1'b1, 5'd13, 32'hD3);
    step(); chk_rf("drained", 1'b0, 5'd0, 32'd0);

    // x_addr 0 is queued but popped without a write
    x_set(1'b1, 5'd0, 32'h55);
    step(); x_set(1'b0, 5'd0, 32'd0);
    chk("x0.we", 32'(bus.rf_we), 32'd0);
    chk("x0.a3", 32'(bus.rf_a3), 32'd0);
    step(); chk_rf("x0.empty", 1'b0, 5'd0, 32'd0);

    // Count held at 3 by simultaneous push/pop; pointers wrap over 10 pushes
    for (int k = 0; k < 10; k++) begin
      if (k < 2) m_set(1'b1, ADDU9, 32'd0, 32'h444, 32'd0);
      else       m_set(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
      x_set(1'b1, 5'(16 + k), 32'(32'h100 + k));
      step();
      chk("pp.x_ready", 32'(bus.x_ready), 32'd1);
      if (k < 2) chk_rf("pp.slot", 1'b1, 5'd9, 32'h444);
      else       chk_rf("pp.head", 1'b1, 5'(14 + k), 32'(32'h100 + k - 2));
    end
    x_set(1'b0, 5'd0, 32'd0);
    step(); chk_rf("pp.tail8", 1'b1, 5'd24, 32'h108);
    step(); chk_rf("pp.tail9", 1'b1, 5'd25, 32'h109);
    step(); chk_rf("pp.empty", 1'b0, 5'd0, 32'd0);

    // Asynchronous reset with 3 queued entries
    m_set(1'b1, ADDU9, 32'd0, 32'h555, 32'd0);
    for (int k = 0; k < 3; k++) begin
      x_set(1'b1, 5'(20 + k), 32'(32'h200 + k));
      step();
    end
    chk_rf("pre_rst", 1'b1, 5'd9, 32'h555);
    m_set(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    x_set(1'b0, 5'd0, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_rf("async_rst", 1'b0, 5'd0, 32'd0);
    chk("async_rst.x_ready", 32'(bus.x_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step(); chk_rf("post_rst0", 1'b0, 5'd0, 32'd0);
    step(); chk_rf("post_rst1", 1'b0, 5'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
